// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The read is combinational: imemRdata/imemReady answer imemAddr in the same cycle.
interface fetch_pc_unit_if;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemReady;

    modport master (output imemAddr, input imemRdata, input imemReady);
    modport slave  (input imemAddr, output imemRdata, output imemReady);
endinterface

// File: rtl/fetch_pc_unit.sv
// IF stage: holds the PC, picks the next PC (PC+4 / branch / JALR) and fills the IF/ID register.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR with a one-cycle trap pulse.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [1:0]             pcSrc,
    input  logic [31:0]            pcTarget,
    input  logic [31:0]            aluResult,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            idPc,
    output logic [31:0]            idPcPlus4,
    output logic [31:0]            idInstr,
    output logic                   idValid,
    output logic                   misalignTrap,
    output logic [31:0]            trapAddr
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    always_comb begin
        redirect = (pcSrc == 2'b01) || (pcSrc == 2'b10);
        // JALR drops bit 0 of rs1+imm; branch targets pass through untouched
        target   = (pcSrc == 2'b10) ? (aluResult & ~32'h1) : pcTarget;
        pc_plus4 = pc_q + 32'd4;

        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        trap_d        = 1'b0;
        trap_addr_d   = trap_addr_q;

        if (redirect) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            if (TRAP_EN && target[1]) begin
                pc_d        = TRAP_VECTOR;
                trap_d      = 1'b1;
                trap_addr_d = target;
            end else if (TRAP_EN) begin
                pc_d = target;
            end else begin
                pc_d = target & ~32'h3;
            end
        end else if (stall) begin
            // everything holds
        end else if (flush || !imem.imemReady) begin
            // bubble; a not-ready fetch retries the same PC next cycle
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else begin
            id_instr_d    = imem.imemRdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
            pc_d          = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_instr_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            trap_q        <= 1'b0;
            trap_addr_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            trap_q        <= trap_d;
            trap_addr_q   <= trap_addr_d;
        end
    end

    assign imem.imemAddr = pc_q;
    assign pc            = pc_q;
    assign idPc          = id_pc_q;
    assign idPcPlus4     = id_pc_plus4_q;
    assign idInstr       = id_instr_q;
    assign idValid       = id_valid_q;
    assign misalignTrap  = trap_q;
    assign trapAddr      = trap_addr_q;

endmodule
